// File: rtl/uart_fifo_bridge.sv
// Byte FIFOs between the core UART ports and the USB-serial UART.
// There is one FIFO per direction. All outputs come straight from registers.

module uart_fifo_bridge_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          wr_valid,
    input  logic [7:0]    wr_data,
    output logic          wr_ready,
    output logic          rd_valid,
    output logic [7:0]    rd_data,
    input  logic          rd_ready,
    output logic [AW:0]   level
);

    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push, pop;

    // Ready and valid look only at the count register.
    // This keeps every input-to-output path broken by a flop.
    assign wr_ready = (count_q != FULL);
    assign rd_valid = (count_q != '0);
    assign rd_data  = mem_q[rd_ptr_q];
    assign level    = count_q;

    assign push = wr_valid && wr_ready;
    assign pop  = rd_valid && rd_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

endmodule

module uart_fifo_bridge #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          core_wr_valid,
    input  logic [7:0]    core_wr_data,
    output logic          core_wr_ready,
    output logic          uart_in_valid,
    output logic [7:0]    uart_in_data,
    input  logic          uart_in_ready,
    input  logic          uart_out_valid,
    input  logic [7:0]    uart_out_data,
    output logic          uart_out_ready,
    output logic          core_rd_valid,
    output logic [7:0]    core_rd_data,
    input  logic          core_rd_ready,
    output logic [AW:0]   tx_level,
    output logic [AW:0]   rx_level
);

    uart_fifo_bridge_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .wr_valid (core_wr_valid),
        .wr_data  (core_wr_data),
        .wr_ready (core_wr_ready),
        .rd_valid (uart_in_valid),
        .rd_data  (uart_in_data),
        .rd_ready (uart_in_ready),
        .level    (tx_level)
    );

    uart_fifo_bridge_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .wr_valid (uart_out_valid),
        .wr_data  (uart_out_data),
        .wr_ready (uart_out_ready),
        .rd_valid (core_rd_valid),
        .rd_data  (core_rd_data),
        .rd_ready (core_rd_ready),
        .level    (rx_level)
    );

endmodule
